// File: rtl/seg7_scan.sv
// Four-digit 7-segment scan driver: rotates one 3-bit digit code per slot onto A/B/C with an active-low digit select.
// Optional leading-zero suppression is compiled in with SEG7_SCAN_LEADZERO_EN.
module seg7_scan #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DIV_W    = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        LOAD,
  input  logic [11:0] DATA,
  input  logic [3:0]  BLANK,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic [3:0]  DIGIT_SEL,
  output logic        TICK
);

  localparam logic [DIV_W-1:0] LP_LAST = DIV_W'(SCAN_DIV - 1);

  logic [11:0]      r_shadow;
  logic [DIV_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [2:0]       r_abc;
  logic [3:0]       r_sel;
  logic             r_tick;

  logic [1:0] w_idx_next;
  logic [2:0] w_digit;
  logic [3:0] w_lz_dark;
  logic       w_dark;
  logic       w_boundary;

`ifdef SEG7_SCAN_LEADZERO_EN
  // Digit k goes dark when it and every more-significant digit are zero; digit 0 always shows.
  logic w_z1, w_z2, w_z3;
  assign w_z1      = (r_shadow[5:3]  == 3'd0);
  assign w_z2      = (r_shadow[8:6]  == 3'd0);
  assign w_z3      = (r_shadow[11:9] == 3'd0);
  assign w_lz_dark = {w_z3, w_z3 & w_z2, w_z3 & w_z2 & w_z1, 1'b0};
`else
  assign w_lz_dark = '0;
`endif

  always_comb begin
    w_idx_next = r_idx + 2'd1;
    w_digit    = r_shadow[2:0];
    case (w_idx_next)
      2'd0: w_digit = r_shadow[2:0];
      2'd1: w_digit = r_shadow[5:3];
      2'd2: w_digit = r_shadow[8:6];
      2'd3: w_digit = r_shadow[11:9];
      default: w_digit = r_shadow[2:0];
    endcase
    w_dark     = BLANK[w_idx_next] | w_lz_dark[w_idx_next];
    w_boundary = (r_cnt == LP_LAST);
  end

  // The boundary reads the pre-edge shadow, so a LOAD on that same edge shows up one frame later.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_shadow <= '0;
      r_cnt    <= '0;
      r_idx    <= 2'd3;
      r_abc    <= '0;
      r_sel    <= '1;
      r_tick   <= 1'b0;
    end else begin
      if (LOAD) begin
        r_shadow <= DATA;
      end
      if (!EN) begin
        r_cnt  <= '0;
        r_sel  <= '1;
        r_tick <= 1'b0;
      end else if (w_boundary) begin
        r_cnt  <= '0;
        r_idx  <= w_idx_next;
        r_abc  <= w_digit;
        r_sel  <= w_dark ? 4'b1111 : ~(4'b0001 << w_idx_next);
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_tick <= 1'b0;
      end
    end
  end

  assign A         = r_abc[2];
  assign B         = r_abc[1];
  assign C         = r_abc[0];
  assign DIGIT_SEL = r_sel;
  assign TICK      = r_tick;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: directed tables/sequences plus randomized stimulus against a cycle reference model.
module tb_seg7_scan;

  localparam int DIV = 4;
`ifdef SEG7_SCAN_LEADZERO_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        EN = 1'b0;
  logic        LOAD = 1'b0;
  logic [11:0] DATA = '0;
  logic [3:0]  BLANK = '0;
  logic        A, B, C;
  logic [3:0]  DIGIT_SEL;
  logic        TICK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int       m_cnt;
  int       m_idx;
  int       m_dig[4];
  logic [2:0] exp_abc;
  logic [3:0] exp_sel;
  logic       exp_tick;

  seg7_scan #(.SCAN_DIV(DIV), .DIV_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .LOAD(LOAD), .DATA(DATA), .BLANK(BLANK),
    .A(A), .B(B), .C(C), .DIGIT_SEL(DIGIT_SEL), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] blank;
    logic [2:0] abc;
    logic [3:0] sel;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_cnt = 0;
    m_idx = 3;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    exp_abc  = 3'd0;
    exp_sel  = 4'hF;
    exp_tick = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic m_step();
    bit dark;
    bit allz;
    if (!EN) begin
      m_cnt    = 0;
      exp_sel  = 4'hF;
      exp_tick = 1'b0;
    end else if (m_cnt == DIV - 1) begin
      m_cnt   = 0;
      m_idx   = (m_idx + 1) % 4;
      exp_abc = 3'(m_dig[m_idx]);
      dark    = BLANK[m_idx];
      if (LZ && m_idx > 0) begin
        allz = 1'b1;
        for (int k = m_idx; k < 4; k++) if (m_dig[k] != 0) allz = 1'b0;
        dark = dark | allz;
      end
      exp_sel  = dark ? 4'hF : 4'(~(4'b0001 << m_idx));
      exp_tick = 1'b1;
    end else begin
      m_cnt++;
      exp_tick = 1'b0;
    end
    if (LOAD) for (int i = 0; i < 4; i++) m_dig[i] = (int'(DATA) >> (3 * i)) & 7;
  endtask

  task automatic cyc();
    m_step();
    @(posedge CLK);
    #1;
    chk("model", {24'd0, A, B, C, DIGIT_SEL, TICK}, {24'd0, exp_abc, exp_sel, exp_tick});
    chk("onehot_low", 32'($countones(~DIGIT_SEL) <= 1), 32'd1);
  endtask

  // Run one full slot; the boundary lands on the last of the DIV edges.
  task automatic slot(input string nm, input logic [2:0] abc, input logic [3:0] sel);
    for (int i = 0; i < DIV - 1; i++) begin
      cyc();
      chk({nm, "_tick_low"}, 32'(TICK), 32'd0);
    end
    cyc();
    chk({nm, "_tick"}, 32'(TICK), 32'd1);
    chk({nm, "_abc"}, 32'({A, B, C}), 32'(abc));
    chk({nm, "_sel"}, 32'(DIGIT_SEL), 32'(sel));
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{4'b0000, 3'o1, 4'b1110};
    tbl[1] = '{4'b0000, 3'o3, 4'b1101};
    tbl[2] = '{4'b0000, 3'o5, 4'b1011};
    tbl[3] = '{4'b0000, 3'o7, 4'b0111};
    tbl[4] = '{4'b0000, 3'o1, 4'b1110};
    tbl[5] = '{4'b0100, 3'o3, 4'b1101};
    tbl[6] = '{4'b0100, 3'o5, 4'b1111};
    tbl[7] = '{4'b0100, 3'o7, 4'b0111};
    tbl[8] = '{4'b0100, 3'o1, 4'b1110};

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      EN = 1'($urandom); LOAD = 1'($urandom); DATA = 12'($urandom); BLANK = 4'($urandom);
      @(posedge CLK);
      #1;
    end
    EN = 1'b0; LOAD = 1'b0; BLANK = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("rst_abc", 32'({A, B, C}), 32'd0);
    chk("rst_sel", 32'(DIGIT_SEL), 32'hF);
    chk("rst_tick", 32'(TICK), 32'd0);
    m_reset();

    // Scan order and blanking
    LOAD = 1'b1; DATA = 12'o7531;
    cyc();
    LOAD = 1'b0; EN = 1'b1;
    for (int i = 0; i < 9; i++) begin
      BLANK = tbl[i].blank;
      slot($sformatf("scan%0d", i), tbl[i].abc, tbl[i].sel);
    end
    BLANK = '0;

    // Pause in mid-slot 1
    slot("pre_pause", 3'o3, 4'b1101);
    cyc();
    EN = 1'b0;
    cyc();
    chk("pause_sel", 32'(DIGIT_SEL), 32'hF);
    chk("pause_tick", 32'(TICK), 32'd0);
    cyc();
    cyc();
    EN = 1'b1;
    slot("resume", 3'o5, 4'b1011);

    // LOAD on the boundary edge into slot 0
    slot("pre_coll", 3'o7, 4'b0111);
    for (int i = 0; i < DIV - 1; i++) cyc();
    LOAD = 1'b1; DATA = 12'o0000;
    cyc();
    LOAD = 1'b0;
    chk("coll_abc", 32'({A, B, C}), 32'o1);
    chk("coll_sel", 32'(DIGIT_SEL), 32'hE);
    slot("zero1", 3'o0, LZ ? 4'b1111 : 4'b1101);
    slot("zero2", 3'o0, LZ ? 4'b1111 : 4'b1011);
    slot("zero3", 3'o0, LZ ? 4'b1111 : 4'b0111);
    slot("zero0", 3'o0, 4'b1110);

    // Leading-zero data 0030, loaded mid slot 0
    LOAD = 1'b1; DATA = 12'o0030;
    cyc();
    LOAD = 1'b0;
    for (int i = 0; i < DIV - 2; i++) cyc();
    cyc();
    chk("lz1_abc", 32'({A, B, C}), 32'o3);
    chk("lz1_sel", 32'(DIGIT_SEL), 32'hD);
    slot("lz2", 3'o0, LZ ? 4'b1111 : 4'b1011);
    slot("lz3", 3'o0, LZ ? 4'b1111 : 4'b0111);
    slot("lz0", 3'o0, 4'b1110);

    // Randomized run against the model
    for (int i = 0; i < 1500; i++) begin
      EN    = ($urandom_range(0, 15) != 0);
      LOAD  = ($urandom_range(0, 7) == 0);
      DATA  = 12'($urandom);
      BLANK = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      cyc();
    end

    // Asynchronous reset between clock edges
    EN = 1'b1; LOAD = 1'b0; BLANK = '0;
    cyc();
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_abc", 32'({A, B, C}), 32'd0);
    chk("arst_sel", 32'(DIGIT_SEL), 32'hF);
    chk("arst_tick", 32'(TICK), 32'd0);
    m_reset();
    #1;
    RST_N = 1'b1;
    slot("post_rst", 3'o0, 4'b1110);
    for (int i = 0; i < 8; i++) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed scan driver for a 4-digit 7-segment display, sitting directly upstream of the 3-input 7-segment decoder. It holds four 3-bit digit codes and selects one digit per scan slot. For that slot it presents the code on A/B/C, which feed the decoder's A/B/C inputs, and drives the matching active-low digit-select line. It also supports per-digit blanking, enable/pause, and a slot-boundary tick.

## Interface
- SCAN_DIV, 50000, clock cycles per digit slot; legal range 2..2^DIV_W-1
- DIV_W, 16, prescaler counter width
- CLK  input  1  system clock, rising edge
- RST_N  input  1  asynchronous reset, active low
- EN  input  1  scan enable; 0 pauses and blanks the display
- LOAD  input  1  capture DATA into the shadow register on this edge
- DATA  input  12  digit codes; digit i = DATA[3i+2:3i]
- BLANK  input  4  per-digit blank mask, 1 = digit i dark
- A, B, C  output  1 each  current digit code; A = MSB (bit 3i+2), C = LSB (bit 3i)
- DIGIT_SEL  output  4  active-low one-hot digit enable; 4'b1111 = all off
- TICK  output  1  one-cycle pulse, high in the first cycle of each new slot

## Operation
- All outputs are registered.
- Reset values:
  - shadow = 0
  - prescaler cnt = 0
  - slot index idx = 3
  - A = B = C = 0
  - DIGIT_SEL = 4'b1111
  - TICK = 0
- Reset mid-operation returns to the reset values immediately, regardless of CLK.
- Shadow register:
  - Any edge with LOAD = 1 writes DATA into shadow.
  - LOAD has no other effect and does not restart the scan.
- Prescaler, EN = 1:
  - cnt counts 0 .. SCAN_DIV-1.
  - On the edge where cnt == SCAN_DIV-1, cnt returns to 0 and a slot boundary occurs.
- At a slot boundary:
  - idx advances 0→1→2→3→0, wrapping after 3.
  - {A,B,C} is loaded with shadow digit idx_next.
  - DIGIT_SEL = ~(1 << idx_next), or 4'b1111 if BLANK[idx_next] = 1 (blank evaluated at the boundary edge).
  - TICK = 1 for that one cycle.
- Between boundaries, A/B/C, DIGIT_SEL and idx hold, and TICK = 0.
- BLANK only affects DIGIT_SEL. A/B/C still carry the digit code.
- EN = 0:
  - On the next edge: cnt cleared to 0, DIGIT_SEL = 4'b1111, TICK = 0.
  - idx and A/B/C hold.
  - After EN returns to 1, the next boundary comes SCAN_DIV edges later and shows digit idx+1.
- LOAD on a boundary edge: that boundary uses the pre-edge shadow. The new data first appears at the following boundary of each digit.
- Scanning does not depend on LOAD. Digits scan from the reset shadow (all zero) until the first LOAD.

## Timing
- Slot length is exactly SCAN_DIV cycles. Frame length is 4·SCAN_DIV cycles.
- From reset release with EN = 1, the first boundary occurs on the SCAN_DIV-th rising edge and shows digit 0 (DIGIT_SEL = 4'b1110).
- Latency from LOAD to display is 1..4·SCAN_DIV cycles, depending on scan position.
- DIGIT_SEL and A/B/C change on the same edge, so no intermediate digit/code mix is ever visible.
- DIGIT_SEL never has more than one bit low.

## Configuration
- SEG7_SCAN_LEADZERO_EN defined: leading-zero suppression.
  - At each boundary, digit k (k = 1..3) is forced dark if shadow digits k..3 are all 0.
  - Digit 0 is never suppressed.
  - Suppression is ORed with BLANK.
- Undefined: no suppression logic is present; only BLANK darkens digits.

## Test plan
- Reset: hold RST_N = 0 with random inputs, then release (EN = 0).
  - Expect DIGIT_SEL = 1111, A/B/C = 000, TICK = 0.
  - Asserting RST_N mid-slot returns the block to these values asynchronously.
- Scan order: SCAN_DIV = 4, LOAD DATA = 12'o7531, EN = 1. Slots of 4 cycles each:
  - ABC = 001, DIGIT_SEL = 1110
  - 011, 1101
  - 101, 1011
  - 111, 0111
  - then wraps to 001 / 1110
  - TICK is high for exactly 1 cycle at each change.
- Blank: BLANK = 4'b0100 with the same data.
  - Slot 2 gives DIGIT_SEL = 1111 with ABC = 101.
  - All other slots are unchanged.
- Pause: drop EN for 3 cycles in mid-slot 1.
  - Next edge gives DIGIT_SEL = 1111 and no TICK.
  - After EN = 1, slot 2 starts exactly 4 cycles later.
- LOAD collision: LOAD 12'o0000 on the boundary edge into slot 0.
  - Slot 0 shows 001.
  - The next frame shows 000 on all digits.
- With SEG7_SCAN_LEADZERO_EN, DATA = 12'o0030:
  - Slots 2 and 3 are dark.
  - Slot 1 shows 011 / 1101; slot 0 shows 000 / 1110.
  - Without the macro, all four slots are lit.
